huffman_decoder: RTL
====================

// Module: huffman_decoder
// PURPOSE
//  Inverse of the huffman code-table generator. Loads the 6-entry code table (HC1..HC6, M1..M6) when code_valid pulses.
//  Then consumes a serial code bitstream, one bit per accepted beat, and emits decoded gray symbols 1..6 over a ready/valid port.
//  Sits downstream of the table generator in the codec loop-back / verification path.
// PARAMETERS
//  MAXLEN   8   maximum code length in bits; also the width of HCn/Mn and of the shift accumulator
//  NSYM     6   number of table entries (fixed structure; not to be changed)
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  asynchronous, active-low reset (0 = reset)
//  code_valid  in   1  single-cycle pulse: HC1..HC6 and M1..M6 are valid this cycle
//  HC1..HC6    in   8  code of symbol n, right-aligned; bit L-1 is transmitted first
//  M1..M6      in   8  mask of symbol n, (1<<L)-1 for length L; 0 = entry unused
//  bit_valid   in   1  bit_data is valid this cycle
//  bit_data    in   1  next code bit, MSB of the code first
//  bit_ready   out  1  decoder accepts bit_data this cycle (beat = bit_valid & bit_ready)
//  sym_valid   out  1  sym_data holds a decoded symbol
//  sym_data    out  8  decoded symbol index, 8'd1..8'd6
//  sym_ready   in   1  consumer takes sym_data (beat = sym_valid & sym_ready)
//  err         out  1  sticky: no table entry matched within MAXLEN bits
//  sym_cnt     out  8  count of symbols handed off since the last table load; wraps 255->0
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=NOTAB; acc=0; len=0; all table registers=0.
//   Outputs after reset: bit_ready=0, sym_valid=0, sym_data=0, err=0, sym_cnt=0.
//  Table load: on code_valid, register HCn and Mn, and register Ln = popcount(Mn).
//   Also clear acc, len, err and sym_cnt, and set sym_valid=0 (any pending symbol is discarded).
//   Next state is IDLE. code_valid has priority over every other event in the same cycle.
//  States:
//   NOTAB: no table loaded; bit_ready=0.
//   IDLE: bit_ready=1; accepts bits.
//   HOLD: sym_valid=1; bit_ready=0.
//   ERR: bit_ready=0; err=1.
//  IDLE, on a bit beat: acc_n = {acc[MAXLEN-2:0], bit_data} and len_n = len+1.
//   A match on entry n requires all three: Mn != 0, len_n == Ln, and (acc_n & Mn) == HCn.
//   Match: sym_data <= n, sym_valid <= 1, acc <= 0, len <= 0; go to HOLD.
//    sym_valid rises the cycle after the completing bit beat (1-cycle latency).
//   Multiple matches (bad table, not prefix-free): the lowest n wins.
//   No match and len_n == MAXLEN: err <= 1; go to ERR.
//   No match, otherwise: stay in IDLE.
//  HOLD: sym_data and sym_valid are stable until a sym_ready beat.
//   On the beat: sym_valid <= 0, sym_cnt <= sym_cnt+1 (mod 256); go to IDLE.
//   Earliest next bit beat is the cycle after handoff, so 1-bit codes give at most 1 symbol per 2 cycles.
//  ERR: stays in ERR until code_valid (reload) or reset; bits are not accepted.
//  With bit_valid=0 in IDLE, acc and len hold.
//  sym_ready while sym_valid=0 is ignored.
//  Reset asserted mid-code or mid-HOLD: the partial code and the pending symbol are lost.
//  The table is also lost and must be reloaded.
// TESTING
//  Common table T:
//   HC1=0/M1=01, HC2=10/M2=03, HC3=110/M3=07, HC4=1110/M4=0F, HC5=11110/M5=1F, HC6=11111/M6=1F (HC in binary, M in hex).
//  1) Reset, then drive bit_valid=1 with no table -> bit_ready=0, sym_valid=0, err=0, sym_cnt=0.
//  2) Load T; stream 0,10,110,1110,11110,11111 with sym_ready=1.
//     -> sym_data 1,2,3,4,5,6 in order; each sym_valid one cycle after the final bit; sym_cnt=6.
//  3) Load T; stream 1,0 with sym_ready=0 for 5 cycles.
//     -> sym_data=2 held, bit_ready=0 throughout; after the ready beat, bit_ready=1 and sym_cnt=1.
//  4) Load a table with all Mn=0; send 8 bits -> err=1 after the 8th beat, bit_ready=0.
//     Reload T -> err=0, decoding resumes.
//  5) Load T; send 1,1 then pulse code_valid together with a bit beat.
//     -> partial code dropped; next stream 0 decodes to sym 1.
//  6) Load T; decode 257 symbols of "0" -> sym_cnt wraps to 1.
//     Assert reset mid-HOLD -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/huffman_decoder.sv
// -----------------------------------------------------------------------------
// huffman_decoder
//   Inverse of the huffman code-table generator. A 6-entry code table
//   (HCn code, Mn mask) is captured on a code_valid pulse. After that, a
//   serial code bitstream (MSB of each code first) is shifted in one bit per
//   accepted beat, and every completed code is emitted as its symbol index
//   1..6 on a ready/valid output port.
//
// Ports
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous, active-low reset
//   code_valid  in   1        single-cycle table-load strobe
//   HC1..HC6    in   MAXLEN   right-aligned code of symbol n
//   M1..M6      in   MAXLEN   mask of symbol n, (1<<L)-1; 0 = entry unused
//   bit_valid   in   1        bit_data valid
//   bit_data    in   1        next code bit
//   bit_ready   out  1        decoder accepts a bit this cycle
//   sym_valid   out  1        sym_data holds a decoded symbol
//   sym_data    out  8        decoded symbol index 1..6
//   sym_ready   in   1        consumer takes sym_data
//   err         out  1        sticky: no entry matched within MAXLEN bits
//   sym_cnt     out  8        symbols handed off since last table load (wraps)
// -----------------------------------------------------------------------------
module huffman_decoder #(
    parameter int MAXLEN = 8,
    parameter int NSYM   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [MAXLEN-1:0] HC1,
    input  logic [MAXLEN-1:0] HC2,
    input  logic [MAXLEN-1:0] HC3,
    input  logic [MAXLEN-1:0] HC4,
    input  logic [MAXLEN-1:0] HC5,
    input  logic [MAXLEN-1:0] HC6,
    input  logic [MAXLEN-1:0] M1,
    input  logic [MAXLEN-1:0] M2,
    input  logic [MAXLEN-1:0] M3,
    input  logic [MAXLEN-1:0] M4,
    input  logic [MAXLEN-1:0] M5,
    input  logic [MAXLEN-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [7:0]        sym_data,
    input  logic              sym_ready,
    output logic              err,
    output logic [7:0]        sym_cnt
);

    localparam int LW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {
        NOTAB = 2'd0,
        IDLE  = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            r_state;
    logic [MAXLEN-1:0] r_hc [NSYM];
    logic [MAXLEN-1:0] r_m  [NSYM];
    logic [LW-1:0]     r_l  [NSYM];
    // The accumulator's top bit is shifted out before any comparison can see
    // it, so only MAXLEN-1 bits are kept; the full MAXLEN-bit value exists
    // only combinationally as w_acc_n.
    logic [MAXLEN-2:0] r_acc;
    logic [LW-1:0]     r_len;
    logic              r_sym_valid;
    logic [7:0]        r_sym_data;
    logic              r_err;
    logic [7:0]        r_sym_cnt;

    logic [MAXLEN-1:0] w_hc_in [NSYM];
    logic [MAXLEN-1:0] w_m_in  [NSYM];
    logic [MAXLEN-1:0] w_acc_n;
    logic [LW-1:0]     w_len_n;
    logic              w_hit;
    logic [7:0]        w_sym;

    assign w_hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
    assign w_m_in  = '{M1, M2, M3, M4, M5, M6};

    function automatic logic [LW-1:0] popcount(input logic [MAXLEN-1:0] v);
        logic [LW-1:0] c;
        c = '0;
        for (int i = 0; i < MAXLEN; i++) c = c + LW'(v[i]);
        return c;
    endfunction

    assign w_acc_n = {r_acc, bit_data};
    assign w_len_n = r_len + 1'b1;

    // Scan from the highest entry down so the lowest matching index is the
    // last writer and wins on a table that is not prefix-free.
    always_comb begin
        // NOTE: every variable gets a default before the loop; without it a
        // no-match cycle would leave them unassigned and infer latches.
        w_hit = 1'b0;
        w_sym = '0;
        for (int n = NSYM - 1; n >= 0; n--) begin
            if ((r_m[n] != '0) && (w_len_n == r_l[n]) &&
                ((w_acc_n & r_m[n]) == r_hc[n])) begin
                w_hit = 1'b1;
                w_sym = 8'(n + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= NOTAB;
            r_acc       <= '0;
            r_len       <= '0;
            r_sym_valid <= 1'b0;
            r_sym_data  <= '0;
            r_err       <= 1'b0;
            r_sym_cnt   <= '0;
            // NOTE: the table registers are reset on purpose: a reset must
            // forget the table, and NOTAB relies on no stale entry surviving.
            for (int n = 0; n < NSYM; n++) begin
                r_hc[n] <= '0;
                r_m[n]  <= '0;
                r_l[n]  <= '0;
            end
        end else if (code_valid) begin
            // Table load overrides whatever else happens this cycle.
            for (int n = 0; n < NSYM; n++) begin
                r_hc[n] <= w_hc_in[n];
                r_m[n]  <= w_m_in[n];
                r_l[n]  <= popcount(w_m_in[n]);
            end
            r_acc       <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_sym_cnt   <= '0;
            r_sym_valid <= 1'b0;
            r_state     <= IDLE;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge register values regardless of statement order.
            unique case (r_state)
                NOTAB: ;
                IDLE: begin
                    if (bit_valid) begin
                        if (w_hit) begin
                            r_sym_data  <= w_sym;
                            r_sym_valid <= 1'b1;
                            r_acc       <= '0;
                            r_len       <= '0;
                            r_state     <= HOLD;
                        end else if (w_len_n == LW'(MAXLEN)) begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end else begin
                            r_acc <= w_acc_n[MAXLEN-2:0];
                            r_len <= w_len_n;
                        end
                    end
                end
                HOLD: begin
                    if (sym_ready) begin
                        r_sym_valid <= 1'b0;
                        r_sym_cnt   <= r_sym_cnt + 8'd1;
                        r_state     <= IDLE;
                    end
                end
                ERR: ;
                default: r_state <= NOTAB;
            endcase
        end
    end

    assign bit_ready = (r_state == IDLE);
    assign sym_valid = r_sym_valid;
    assign sym_data  = r_sym_data;
    assign err       = r_err;
    assign sym_cnt   = r_sym_cnt;

endmodule
